// File: rtl/freq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : freq_pkg
// Purpose : Shared types, default parameters and the period clamp helper for
//           the frequency-step gate generator.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package freq_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int unsigned DEF_PERIOD_W    = 16;
  localparam int unsigned DEF_PERIOD_INIT = 1250;
  localparam int unsigned DEF_PERIOD_MIN  = 1000;
  localparam int unsigned DEF_PERIOD_MAX  = 1500;
  localparam int unsigned DEF_STEP        = 5;
  localparam int unsigned DEF_DEADTIME    = 25;

  // v is a widened step result; bit 32 set means the subtraction went below
  // zero, which must clamp to the lower bound rather than wrap.
  function automatic logic [31:0] clamp_period(input logic [32:0] v,
                                               input logic [31:0] lo,
                                               input logic [31:0] hi);
    logic [31:0] r;
    if (v[32])             r = lo;
    else if (v[31:0] < lo) r = lo;
    else if (v[31:0] > hi) r = hi;
    else                   r = v[31:0];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/freq_gate_dt.sv
`default_nettype none
// ============================================================================
// Module  : freq_gate_dt
// Purpose : Period counter and dead-time protected complementary gate / sync
//           generation for one switching period of length 'period'.
// Ports   : clk, rst      - clock, async active-high reset
//           run_cur       - generator running this cycle
//           run_next      - generator running next cycle
//           period        - period currently in effect (clk cycles)
//           wrap          - this cycle is the last count of the period
//           gate_hi/lo    - registered gate drives
//           sync          - registered pulse on count 0 of each period
// Revision: 1.0 - initial release
// ============================================================================
module freq_gate_dt #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned DEADTIME = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_cur,
  input  logic                run_next,
  input  logic [PERIOD_W-1:0] period,
  output logic                wrap,
  output logic                gate_hi,
  output logic                gate_lo,
  output logic                sync
);

  localparam logic [PERIOD_W-1:0] DT = PERIOD_W'(DEADTIME);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] half;
  logic                gate_hi_q, gate_hi_d;
  logic                gate_lo_q, gate_lo_d;
  logic                sync_q, sync_d;

  assign half = period >> 1;
  assign wrap = run_cur && (cnt_q == period - PERIOD_W'(1));

  // Outputs are decoded from the next count so the registered gates line up
  // with cnt_q in the same cycle. The period can only change at wrap, where
  // cnt_d is 0 and both gates are low for any period, so using the current
  // period here is safe.
  always_comb begin
    cnt_d = '0;
    if (run_cur && run_next && !wrap) begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
    gate_hi_d = run_next && (cnt_d >= DT) && (cnt_d < half);
    gate_lo_d = run_next && (cnt_d >= half + DT) && (cnt_d < period);
    sync_d    = run_next && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      gate_hi_q <= 1'b0;
      gate_lo_q <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      gate_hi_q <= gate_hi_d;
      gate_lo_q <= gate_lo_d;
      sync_q    <= sync_d;
    end
  end

  assign gate_hi = gate_hi_q;
  assign gate_lo = gate_lo_q;
  assign sync    = sync_q;

endmodule
`default_nettype wire

// File: rtl/freq_step_gen.sv
`default_nettype none
// ============================================================================
// Module  : freq_step_gen
// Purpose : Accepts frequency step requests, owns the switching-period
//           register (with clamp and lock) and drives complementary
//           dead-time protected gates plus a period-start sync.
// Ports   : clk, rst          - clock, async active-high reset
//           en                - run enable (low: gates off, counter at 0)
//           freq_rdy          - step request strobe
//           freq_set_up_down  - direction with freq_rdy, 1 = frequency up
//           freq_opt          - optimum found, locks the period
//           relock            - clears lock
//           gate_hi, gate_lo  - gate drives
//           sync              - first cycle of each period
//           period_out        - period in effect
//           locked            - lock state
//           at_limit          - period at PERIOD_MIN or PERIOD_MAX
// Config  : FREQ_STEP_SOFTSTART_EN - ramp period down from PERIOD_MAX to
//           PERIOD_INIT after each enable.
// Revision: 1.0 - initial release
// ============================================================================
module freq_step_gen
  import freq_pkg::*;
#(
  parameter int unsigned PERIOD_W    = DEF_PERIOD_W,
  parameter int unsigned PERIOD_INIT = DEF_PERIOD_INIT,
  parameter int unsigned PERIOD_MIN  = DEF_PERIOD_MIN,
  parameter int unsigned PERIOD_MAX  = DEF_PERIOD_MAX,
  parameter int unsigned STEP        = DEF_STEP,
  parameter int unsigned DEADTIME    = DEF_DEADTIME
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                freq_rdy,
  input  logic                freq_set_up_down,
  input  logic                freq_opt,
  input  logic                relock,
  output logic                gate_hi,
  output logic                gate_lo,
  output logic                sync,
  output logic [PERIOD_W-1:0] period_out,
  output logic                locked,
  output logic                at_limit
);

  localparam logic [31:0] MIN32  = 32'(PERIOD_MIN);
  localparam logic [31:0] MAX32  = 32'(PERIOD_MAX);
  localparam logic [32:0] STEP33 = 33'(STEP);

  state_e              state_q, state_d;
  logic                locked_q, locked_d;
  logic                pend_q, pend_d;
  logic                pend_up_q, pend_up_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                ramp;
  logic                wrap, run_cur, run_next;
  logic                take_opt, take_rdy, apply, step_up;
  logic [32:0]         period_ext, period_req;

`ifdef FREQ_STEP_SOFTSTART_EN
  localparam logic [31:0] INIT32 = 32'(PERIOD_INIT);
  logic        ramp_q, ramp_d;
  logic [31:0] ramp_next;
  assign ramp      = ramp_q;
  // The ramp floor is PERIOD_INIT, so clamping against it ends the ramp.
  assign ramp_next = clamp_period(period_ext - STEP33, INIT32, MAX32);
`else
  assign ramp = 1'b0;
`endif

  assign run_cur    = (state_q != ST_OFF);
  assign run_next   = (state_d != ST_OFF);
  // Step arithmetic is widened so neither direction can wrap before clamping.
  assign period_ext = 33'(period_q);
  assign period_req = step_up ? (period_ext - STEP33) : (period_ext + STEP33);

  always_comb begin
    // Lock beats a simultaneous request; relock beats a simultaneous lock.
    take_opt = (state_q == ST_RUN) && en && freq_opt && !relock && !ramp;
    take_rdy = (state_q == ST_RUN) && en && freq_rdy && !take_opt && !ramp;
    step_up  = take_rdy ? freq_set_up_down : pend_up_q;
    apply    = wrap && !take_opt &&
               (take_rdy || (pend_q && (state_q == ST_RUN) && en && !ramp));

    locked_d = locked_q;
    if (relock)        locked_d = 1'b0;
    else if (take_opt) locked_d = 1'b1;

    // Lock survives a disable, so re-enabling returns to the held state.
    if (!en)           state_d = ST_OFF;
    else if (locked_d) state_d = ST_LOCKED;
    else               state_d = ST_RUN;

    pend_d    = pend_q;
    pend_up_d = pend_up_q;
    if (take_opt || wrap || !(en && (state_q == ST_RUN))) begin
      pend_d = 1'b0;
    end else if (take_rdy) begin
      pend_d    = 1'b1;
      pend_up_d = freq_set_up_down;
    end

    period_d = period_q;
`ifdef FREQ_STEP_SOFTSTART_EN
    ramp_d = ramp_q;
    if (!en) begin
      ramp_d = 1'b0;
    end else if (state_q == ST_OFF) begin
      period_d = PERIOD_W'(MAX32);
      ramp_d   = (MAX32 > INIT32);
    end else if (ramp_q && wrap) begin
      period_d = PERIOD_W'(ramp_next);
      ramp_d   = (ramp_next != INIT32);
    end else if (apply) begin
      period_d = PERIOD_W'(clamp_period(period_req, MIN32, MAX32));
    end
`else
    if (apply) begin
      period_d = PERIOD_W'(clamp_period(period_req, MIN32, MAX32));
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OFF;
      locked_q  <= 1'b0;
      pend_q    <= 1'b0;
      pend_up_q <= 1'b0;
      period_q  <= PERIOD_W'(PERIOD_INIT);
`ifdef FREQ_STEP_SOFTSTART_EN
      ramp_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      locked_q  <= locked_d;
      pend_q    <= pend_d;
      pend_up_q <= pend_up_d;
      period_q  <= period_d;
`ifdef FREQ_STEP_SOFTSTART_EN
      ramp_q    <= ramp_d;
`endif
    end
  end

  freq_gate_dt #(
    .PERIOD_W (PERIOD_W),
    .DEADTIME (DEADTIME)
  ) u_gate (
    .clk      (clk),
    .rst      (rst),
    .run_cur  (run_cur),
    .run_next (run_next),
    .period   (period_q),
    .wrap     (wrap),
    .gate_hi  (gate_hi),
    .gate_lo  (gate_lo),
    .sync     (sync)
  );

  assign period_out = period_q;
  assign locked     = locked_q;
  assign at_limit   = (period_q == PERIOD_W'(PERIOD_MIN)) ||
                      (period_q == PERIOD_W'(PERIOD_MAX));

endmodule
`default_nettype wire

// File: tb/tb_freq_step_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_freq_step_gen
// Purpose : Self-checking bench for freq_step_gen (default build): gate
//           waveform vectors, step requests, clamp, lock and async reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_freq_step_gen;

  logic        clk = 1'b0;
  logic        rst, en, freq_rdy, freq_set_up_down, freq_opt, relock;
  logic        gate_hi, gate_lo, sync, locked, at_limit;
  logic [15:0] period_out;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int model_p;

  typedef struct {
    int cnt;
    bit hi;
    bit lo;
    bit sy;
  } vec_t;

  vec_t t1[8];
  vec_t vt[8];

  freq_step_gen dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .freq_rdy         (freq_rdy),
    .freq_set_up_down (freq_set_up_down),
    .freq_opt         (freq_opt),
    .relock           (relock),
    .gate_hi          (gate_hi),
    .gate_lo          (gate_lo),
    .sync             (sync),
    .period_out       (period_out),
    .locked           (locked),
    .at_limit         (at_limit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Shoot-through guard on every running cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (gate_hi && gate_lo) begin
        errors++;
        $display("FAIL overlap: gate_hi=%0d gate_lo=%0d expected not both 1", gate_hi, gate_lo);
      end
    end
  end

  function automatic int model_step(input int p, input bit up);
    int r;
    r = up ? p - 5 : p + 5;
    if (r < 1000) r = 1000;
    if (r > 1500) r = 1500;
    return r;
  endfunction

  task automatic wait_sync(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sync && n < 3000);
    if (!sync) begin
      checks++;
      errors++;
      $display("FAIL %s: sync=0 after %0d cycles, expected a sync pulse", name, n);
    end
  endtask

  task automatic pop_check(input string name);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, period_out=%0d", name, period_out);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_period"}, int'(period_out), e);
      chk({name, "_sync"}, int'(sync), 1);
    end
  endtask

  task automatic next_period_check(input string name);
    wait_sync(name);
    pop_check(name);
  endtask

  task automatic build_vectors(input int p);
    int h;
    h = p / 2;
    vt[0] = '{0,          1'b0, 1'b0, 1'b1};
    vt[1] = '{24,         1'b0, 1'b0, 1'b0};
    vt[2] = '{25,         1'b1, 1'b0, 1'b0};
    vt[3] = '{h - 1,      1'b1, 1'b0, 1'b0};
    vt[4] = '{h,          1'b0, 1'b0, 1'b0};
    vt[5] = '{h + 24,     1'b0, 1'b0, 1'b0};
    vt[6] = '{h + 25,     1'b0, 1'b1, 1'b0};
    vt[7] = '{p - 1,      1'b0, 1'b1, 1'b0};
  endtask

  // Entered on the sync cycle (cnt 0); leaves on the last cycle of the period.
  task automatic run_vectors(input string name);
    int cur;
    cur = 0;
    for (int i = 0; i < 8; i++) begin
      repeat (vt[i].cnt - cur) @(negedge clk);
      cur = vt[i].cnt;
      chk($sformatf("%s_hi@%0d", name, cur), int'(gate_hi), int'(vt[i].hi));
      chk($sformatf("%s_lo@%0d", name, cur), int'(gate_lo), int'(vt[i].lo));
      chk($sformatf("%s_sync@%0d", name, cur), int'(sync), int'(vt[i].sy));
    end
  endtask

  task automatic pulse_rdy(input bit up);
    freq_rdy         = 1'b1;
    freq_set_up_down = up;
    @(negedge clk);
    freq_rdy = 1'b0;
  endtask

  initial begin
    t1[0] = '{0,    1'b0, 1'b0, 1'b1};
    t1[1] = '{24,   1'b0, 1'b0, 1'b0};
    t1[2] = '{25,   1'b1, 1'b0, 1'b0};
    t1[3] = '{624,  1'b1, 1'b0, 1'b0};
    t1[4] = '{625,  1'b0, 1'b0, 1'b0};
    t1[5] = '{649,  1'b0, 1'b0, 1'b0};
    t1[6] = '{650,  1'b0, 1'b1, 1'b0};
    t1[7] = '{1249, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; en = 1'b0; freq_rdy = 1'b0; freq_set_up_down = 1'b0;
    freq_opt = 1'b0; relock = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_gate_hi", int'(gate_hi), 0);
    chk("rst_gate_lo", int'(gate_lo), 0);
    chk("rst_sync", int'(sync), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_period", int'(period_out), 1250);
    chk("rst_at_limit", int'(at_limit), 0);

    // Enable and check the nominal waveform.
    rst = 1'b0; en = 1'b1;
    model_p = 1250;
    exp_q.push_back(model_p);
    next_period_check("t1");
    vt = t1;
    run_vectors("t1");
    chk("t1_at_limit", int'(at_limit), 0);

    // Single up request mid-period, applied at the next wrap.
    exp_q.push_back(model_p);
    next_period_check("t2_pre");
    repeat (100) @(negedge clk);
    pulse_rdy(1'b1);
    model_p = model_step(model_p, 1'b1);
    exp_q.push_back(model_p);
    chk("t2_hold", int'(period_out), 1250);
    next_period_check("t2");
    build_vectors(model_p);
    run_vectors("t2");

    // Two requests in one period: the later one wins.
    exp_q.push_back(model_p);
    next_period_check("t3_pre");
    repeat (50) @(negedge clk);
    pulse_rdy(1'b1);
    repeat (200) @(negedge clk);
    pulse_rdy(1'b0);
    model_p = model_step(model_p, 1'b0);
    exp_q.push_back(model_p);
    next_period_check("t3_last_wins");

    // Request on the wrap cycle itself takes effect at that wrap.
    repeat (model_p - 1) @(negedge clk);
    pulse_rdy(1'b1);
    model_p = model_step(model_p, 1'b1);
    exp_q.push_back(model_p);
    pop_check("t3_wrap_req");

    // Lock discards a pending request and wins over a simultaneous one.
    repeat (10) @(negedge clk);
    pulse_rdy(1'b1);
    repeat (9) @(negedge clk);
    freq_rdy = 1'b1; freq_set_up_down = 1'b1; freq_opt = 1'b1;
    @(negedge clk);
    freq_rdy = 1'b0; freq_opt = 1'b0;
    chk("t5_locked", int'(locked), 1);
    repeat (100) @(negedge clk);
    pulse_rdy(1'b1);
    exp_q.push_back(model_p);
    next_period_check("t5_locked_hold");
    chk("t5_locked_still", int'(locked), 1);
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    chk("t5_relock", int'(locked), 0);
    relock = 1'b1; freq_opt = 1'b1;
    @(negedge clk);
    relock = 1'b0; freq_opt = 1'b0;
    chk("t5_relock_wins", int'(locked), 0);
    pulse_rdy(1'b1);
    model_p = model_step(model_p, 1'b1);
    exp_q.push_back(model_p);
    next_period_check("t5_resume");

    // Repeated up requests saturate at the minimum period.
    for (int i = 0; i < 51; i++) begin
      repeat (5) @(negedge clk);
      pulse_rdy(1'b1);
      model_p = model_step(model_p, 1'b1);
      exp_q.push_back(model_p);
      next_period_check($sformatf("t4_step%0d", i));
      chk($sformatf("t4_at_limit%0d", i), int'(at_limit),
          int'(model_p == 1000 || model_p == 1500));
    end
    chk("t4_final", int'(period_out), 1000);
    build_vectors(model_p);
    run_vectors("t4");

    // Asynchronous reset mid-period.
    wait_sync("t6_pre");
    repeat (700) @(negedge clk);
    chk("t6_pre_lo", int'(gate_lo), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_hi", int'(gate_hi), 0);
    chk("t6_rst_lo", int'(gate_lo), 0);
    chk("t6_rst_sync", int'(sync), 0);
    chk("t6_rst_period", int'(period_out), 1250);
    @(negedge clk);
    rst = 1'b0;
    model_p = 1250;
    exp_q.push_back(model_p);
    next_period_check("t6_restart");
    build_vectors(model_p);
    run_vectors("t6");
    chk("t6_locked", int'(locked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
